// File: rtl/debug_pipe_ctrl.sv
// debug_pipe_ctrl: run/step/done controller for a debug pipeline. It drives
// the advance enable and the flush pulse for every pipeline latch.
// Latency: a command sampled at rising edge k shows on the registered outputs after edge k.
// Backpressure: none. Commands that do not apply in the current state are dropped.
//
// Ports:
//   clk          system clock. All state updates on the rising edge.
//   reset        synchronous active-high reset.
//   start        begins execution. Only accepted in IDLE.
//   mode_step    selects the execution mode when start is accepted: 1 = step, 0 = continuous.
//   step         advances the pipeline by one clock. Only used in STEP.
//   clear        flushes the pipeline and returns the block to IDLE.
//   eop_wb       end-of-program flag seen at the WB stage.
//   enableDebug  registered advance enable to the pipeline latches.
//   resetDebug   registered one-cycle flush pulse to the pipeline latches.
//   state        current state: IDLE=00, RUN=01, STEP=10, DONE=11.
//   done         registered. High while state is DONE.
//   cycle_count  number of enabled cycles since the last reset or clear. Saturates at all-ones.
module debug_pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_step,
  input  logic        step,
  input  logic        clear,
  input  logic        eop_wb,
  output logic        enableDebug,
  output logic        resetDebug,
  output logic [1:0]  state,
  output logic        done,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   enable_nxt;
  logic   flush_nxt;

  // Next-state and next-output logic.
  // Priority is clear first, then eop_wb, then start or step.
  // Reset is handled in the register block.
  always_comb begin
    nxt_state  = cur_state;
    enable_nxt = 1'b0;
    flush_nxt  = 1'b0;
    if (clear) begin
      nxt_state = IDLE;
      flush_nxt = 1'b1;
    end else begin
      unique case (cur_state)
        IDLE: begin
          if (start) begin
            if (mode_step) begin
              nxt_state = STEP;
            end else begin
              nxt_state  = RUN;
              enable_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          // Drop the enable at the same edge that eop reaches WB.
          // This stops the latches from advancing past the end of the program.
          if (eop_wb) begin
            nxt_state = DONE;
          end else begin
            enable_nxt = 1'b1;
          end
        end
        STEP: begin
          // The enable follows each step pulse cycle for cycle.
          // Adjacent step pulses therefore give adjacent enable cycles.
          if (eop_wb) begin
            nxt_state = DONE;
          end else begin
            enable_nxt = step;
          end
        end
        DONE: begin
          nxt_state = DONE;
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // The latches receive reset directly, so no flush pulse is issued here.
      cur_state   <= IDLE;
      enableDebug <= 1'b0;
      resetDebug  <= 1'b0;
      done        <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      cur_state   <= nxt_state;
      enableDebug <= enable_nxt;
      resetDebug  <= flush_nxt;
      done        <= (nxt_state == DONE);
      if (clear) begin
        cycle_count <= 32'd0;
      end else if (enableDebug && (cycle_count != 32'hFFFF_FFFF)) begin
        // Count against the enable the latches actually saw at this edge.
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

  assign state = cur_state;

endmodule
